// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//   The clock and data pins are synchronized. The clock is then glitch-filtered.
//   Each 11-bit frame is framed on the filtered falling edges, and a checked
//   byte is delivered through a valid/ready holding register.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins
//   rx_data, rx_valid  received byte and its unconsumed flag
//   rx_ready           consumer accepts rx_data when rx_valid && rx_ready
//   parity_err         one-cycle pulse, parity check failed
//   frame_err          one-cycle pulse, bad stop bit or inter-edge timeout
//   overflow           one-cycle pulse, good byte dropped (holding reg full)
//
// state    | meaning
// S_IDLE   | waiting for a start bit (falling edge with data low)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then delivering or flagging
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_to_cnt;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_par;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid, r_parity_err, r_frame_err, r_overflow;

    logic w_filt_flip, w_fall, w_timeout, w_par_ok;
    logic w_deliver, w_par_err, w_frm_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // r_filt_cnt counts consecutive samples that disagree with r_filt; the
    // FILTER_LEN-th one flips the filtered level.
    assign w_filt_flip = (r_clk_s2 != r_filt) && (r_filt_cnt == FILT_LAST);
    // The edge is flagged in the cycle r_filt drops, so data is sampled here.
    assign w_fall      = w_filt_flip && r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt     <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // The counter is zero in the cycle after an edge. The timeout therefore
    // shows on frame_err TIMEOUT_CYC cycles after the filtered clock fell.
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (w_fall || r_state == S_IDLE || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_par_ok = ^{r_shift, r_par};

    always_comb begin
        w_deliver = 1'b0;
        w_par_err = 1'b0;
        w_frm_err = 1'b0;
        if (w_fall && r_state == S_STOP) begin
            if (!r_dat_s2)
                w_frm_err = 1'b1;
            else if (w_par_ok)
                w_deliver = 1'b1;
            else
                w_par_err = 1'b1;
        end
        if (w_timeout)
            w_frm_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   r_bit_cnt <= '0;
                S_DATA: begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_PARITY: r_par <= r_dat_s2;
                default:  ;
            endcase
        end
    end

    // A delivery in the handshake cycle replaces the consumed byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_parity_err <= w_par_err;
            r_frame_err  <= w_frm_err;
            r_overflow   <= w_deliver && r_rx_valid && !rx_ready;
            if (w_deliver && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule
